// File: rtl/axis_frame_gen.sv
// ---------------------------------------------------------------------------
// axis_frame_gen
// Synthetic AXI4-Stream frame source. A single-cycle start command launches
// a counting-pattern frame (beat k carries seed + k) of frame_len beats. The
// source honours tready backpressure, can truncate a frame on request with
// an error-marked last beat (tuser=1), and inserts GAP_CYCLES idle cycles
// after each frame.
//
// Optional feature macro: AXIS_FRAME_GEN_ERR_INJ_EN
//   When defined, an err_inject input is added. It is latched with start,
//   and the frame is then sent at full length with tuser=1 on its last beat.
//
// Ports:
//   clk                 single clock, rising edge
//   rst                 synchronous active-high reset
//   start               start command, only acted on in IDLE
//   frame_len           frame length in beats (0 = ignore the start)
//   seed                tdata of beat 0
//   abort               request early termination of the current frame
//   err_inject          (macro only) mark the frame bad on its last beat
//   output_axis_*       AXI4-Stream master (tdata/tvalid/tready/tlast/tuser)
//   busy                high whenever not IDLE
//   frame_count         frames completed (tlast accepted), wraps at 16 bits
// ---------------------------------------------------------------------------
module axis_frame_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  abort,
`ifdef AXIS_FRAME_GEN_ERR_INJ_EN
    input  logic                  err_inject,
`endif
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,
    output logic                  busy,
    output logic [15:0]           frame_count
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic                  abort_q, abort_d;
    logic                  err_q, err_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [15:0]           count_q, count_d;

    logic                  err_in;
    logic                  start_ok;
    logic                  xfer;
    logic [LEN_WIDTH-1:0]  beat_nxt;
    logic                  nxt_is_last;

`ifdef AXIS_FRAME_GEN_ERR_INJ_EN
    assign err_in = err_inject;
`else
    assign err_in = 1'b0;
`endif

    assign start_ok    = start && (frame_len != '0);
    assign xfer        = (state_q == S_SEND) && output_axis_tready;
    assign beat_nxt    = beat_q + LEN_WIDTH'(1);
    assign nxt_is_last = (beat_nxt == len_q - LEN_WIDTH'(1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tdata_q <= '0;
            tlast_q <= 1'b0;
            tuser_q <= 1'b0;
            len_q   <= '0;
            beat_q  <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            gap_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
            tuser_q <= tuser_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
            count_q <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_ok) state_d = S_SEND;
            S_SEND: if (xfer && tlast_q) state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            S_GAP:  if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Beat generation, abort latch, gap counter, frame counter
    always_comb begin
        tdata_d = tdata_q;
        tlast_d = tlast_q;
        tuser_d = tuser_q;
        len_d   = len_q;
        beat_d  = beat_q;
        abort_d = abort_q;
        err_d   = err_q;
        gap_d   = gap_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    len_d   = frame_len;
                    tdata_d = seed;
                    beat_d  = '0;
                    tlast_d = (frame_len == LEN_WIDTH'(1));
                    tuser_d = (frame_len == LEN_WIDTH'(1)) && err_in;
                    err_d   = err_in;
                    abort_d = 1'b0;
                end
            end
            S_SEND: begin
                abort_d = abort_q || abort;
                if (xfer) begin
                    if (tlast_q) begin
                        // Frame done; a pending abort is dropped, so a frame
                        // whose last beat was already presented ends clean.
                        count_d = count_q + 16'd1;
                        abort_d = 1'b0;
                        tlast_d = 1'b0;
                        tuser_d = 1'b0;
                        gap_d   = '0;
                    end else begin
                        tdata_d = tdata_q + DATA_WIDTH'(1);
                        beat_d  = beat_nxt;
                        // The same-cycle abort input counts, so an abort seen
                        // as beat k transfers truncates at beat k+1.
                        if (abort_q || abort) begin
                            tlast_d = 1'b1;
                            tuser_d = 1'b1;
                        end else begin
                            tlast_d = nxt_is_last;
                            tuser_d = nxt_is_last && err_q;
                        end
                    end
                end
            end
            S_GAP: gap_d = gap_q + GW'(1);
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        output_axis_tvalid = (state_q == S_SEND);
        output_axis_tdata  = tdata_q;
        output_axis_tlast  = tlast_q;
        output_axis_tuser  = tuser_q;
        busy               = (state_q != S_IDLE);
        frame_count        = count_q;
    end

endmodule

// File: tb/tb_axis_frame_gen.sv
module tb_axis_frame_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  frame_len;
    logic [7:0]  seed;
    logic        abort;
    logic        err_inject;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;
    logic        busy;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    axis_frame_gen #(.DATA_WIDTH(8), .LEN_WIDTH(8), .GAP_CYCLES(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .frame_len          (frame_len),
        .seed               (seed),
        .abort              (abort),
`ifdef AXIS_FRAME_GEN_ERR_INJ_EN
        .err_inject         (err_inject),
`endif
        .output_axis_tdata  (tdata),
        .output_axis_tvalid (tvalid),
        .output_axis_tready (tready),
        .output_axis_tlast  (tlast),
        .output_axis_tuser  (tuser),
        .busy               (busy),
        .frame_count        (frame_count)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_xfers  = 0;
    logic [15:0] exp_fc   = 16'd0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard pop on every transfer, stability check on stalls
    logic       prev_stall = 1'b0;
    logic [9:0] prev_beat;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_tvalid", {31'd0, tvalid}, 32'd1);
                check_val("stall_hold", {22'd0, tdata, tlast, tuser}, {22'd0, prev_beat});
            end
            if (tvalid && tready) begin
                n_xfers++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_beat", {24'd0, tdata}, 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check_val("beat_data", {24'd0, tdata}, {24'd0, e.data});
                    check_val("beat_last", {31'd0, tlast}, {31'd0, e.last});
                    check_val("beat_user", {31'd0, tuser}, {31'd0, e.user});
                end
            end
            prev_stall = tvalid && !tready;
            prev_beat  = {tdata, tlast, tuser};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start and push the frame the sink should see
    task automatic start_frame(input int len, input logic [7:0] sd, input logic err,
                               input int exp_len, input logic exp_user);
        frame_len  = len[7:0];
        seed       = sd;
        err_inject = err;
        start      = 1'b1;
        for (int k = 0; k < exp_len; k++) begin
            beat_t b;
            b.data = sd + k[7:0];
            b.last = (k == exp_len - 1);
            b.user = (k == exp_len - 1) ? exp_user : 1'b0;
            exp_q.push_back(b);
        end
        tick();
        start = 1'b0;
        check_val("start_tvalid", {31'd0, tvalid}, 32'd1);
        check_val("start_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        check_val("idle_timeout", {31'd0, (n >= 300)}, 32'd0);
        check_val("queue_empty", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; frame_len = '0; seed = '0;
        abort = 1'b0; err_inject = 1'b0; tready = 1'b1;
        tick(); tick();
        check_val("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check_val("rst_tdata", {24'd0, tdata}, 32'd0);
        check_val("rst_tlast", {31'd0, tlast}, 32'd0);
        check_val("rst_tuser", {31'd0, tuser}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_fc", {16'd0, frame_count}, 32'd0);
        rst = 1'b0;
        tick();

        // Counting pattern with wrap, then two gap cycles
        start_frame(4, 8'hFE, 1'b0, 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_val("b2b_valid", {31'd0, tvalid}, 32'd1);
            tick();
        end
        exp_fc++;
        for (int g = 0; g < 2; g++) begin
            check_val("gap_tvalid", {31'd0, tvalid}, 32'd0);
            check_val("gap_busy", {31'd0, busy}, 32'd1);
        check_val("gap_fc", {16'd0, frame_count}, {16'd0, exp_fc});
            tick();
        end
        check_val("after_gap_busy", {31'd0, busy}, 32'd0);

        // Backpressure: tready toggles every cycle
        n_xfers = 0;
        tready = 1'b0;
        start_frame(3, 8'h30, 1'b0, 3, 1'b0);
        for (int n = 0; n < 40 && busy; n++) begin
            tready = ~tready;
            tick();
        end
        tready = 1'b1;
        wait_idle();
        exp_fc++;
        check_val("bp_xfers", n_xfers, 32'd3);
        check_val("bp_fc", {16'd0, frame_count}, {16'd0, exp_fc});

        // Abort pulsed while beat 2 transfers -> beat 3 truncates with tuser
        start_frame(10, 8'h00, 1'b0, 4, 1'b1);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_tlast", {31'd0, tlast}, 32'd1);
        check_val("abort_tuser", {31'd0, tuser}, 32'd1);
        wait_idle();
        exp_fc++;
        repeat (4) tick();
        check_val("abort_fc", {16'd0, frame_count}, {16'd0, exp_fc});

        // Abort while the last beat is presented is discarded
        tready = 1'b0;
        start_frame(2, 8'h50, 1'b0, 2, 1'b0);
        tready = 1'b1;
        tick();
        abort = 1'b1;
        tready = 1'b0;
        tick();
        abort = 1'b0;
        tready = 1'b1;
        wait_idle();
        exp_fc++;

        // Zero-length start is ignored
        frame_len = 8'd0; seed = 8'h77; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("len0_busy", {31'd0, busy}, 32'd0);
        check_val("len0_tvalid", {31'd0, tvalid}, 32'd0);
        repeat (3) tick();
        check_val("len0_fc", {16'd0, frame_count}, {16'd0, exp_fc});

        // Start during SEND is ignored
        start_frame(5, 8'h10, 1'b0, 5, 1'b0);
        frame_len = 8'd2; seed = 8'hAA; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        exp_fc++;
        repeat (4) tick();
        check_val("busy_start_fc", {16'd0, frame_count}, {16'd0, exp_fc});
        check_val("busy_start_idle", {31'd0, busy}, 32'd0);

        // Reset while beat 5 of an 8-beat frame is presented
        start_frame(8, 8'h40, 1'b0, 8, 1'b0);
        repeat (5) tick();
        check_val("pre_rst_data", {24'd0, tdata}, 32'h45);
        rst = 1'b1;
        tick();
        exp_q.delete();
        rst = 1'b0;
        exp_fc = 16'd0;
        check_val("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
        check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_val("mid_rst_fc", {16'd0, frame_count}, 32'd0);
        start_frame(1, 8'h9C, 1'b0, 1, 1'b0);
        check_val("len1_tlast", {31'd0, tlast}, 32'd1);
        wait_idle();
        exp_fc++;
        check_val("post_rst_fc", {16'd0, frame_count}, {16'd0, exp_fc});

`ifdef AXIS_FRAME_GEN_ERR_INJ_EN
        start_frame(2, 8'h20, 1'b1, 2, 1'b1);
        wait_idle();
        start_frame(2, 8'h60, 1'b0, 2, 1'b0);
        wait_idle();
        exp_fc += 16'd2;
        check_val("errinj_fc", {16'd0, frame_count}, {16'd0, exp_fc});
`endif

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_frame_gen.md
# axis_frame_gen

Synthetic AXI4-Stream frame source that drives the input side of the frame FIFO (and any other AXI-Stream sink) with counting-pattern frames of programmable length. Each frame is started by a single-cycle command, honours full tready backpressure, and can be truncated with an error-marked last beat (tuser=1), so the FIFO's bad-frame and drop paths can be exercised. The block sits in bench and bring-up datapaths upstream of the frame FIFO.

## Interface
- DATA_WIDTH, 8, tdata width; pattern arithmetic is mod 2^DATA_WIDTH
- LEN_WIDTH, 8, width of frame_len; maximum frame 2^LEN_WIDTH-1 beats
- GAP_CYCLES, 2, idle cycles with tvalid low after each frame's last beat is accepted (0 allowed)

- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  start command; sampled only in IDLE
- frame_len  input  LEN_WIDTH  beats in frame, latched on accepted start
- seed  input  DATA_WIDTH  tdata of beat 0, latched on accepted start
- abort  input  1  request early termination of current frame
- output_axis_tdata  output  DATA_WIDTH  beat data
- output_axis_tvalid  output  1  beat valid
- output_axis_tready  input  1  sink ready
- output_axis_tlast  output  1  last beat of frame
- output_axis_tuser  output  1  frame bad; meaningful only with tlast
- busy  output  1  high whenever state is not IDLE
- frame_count  output  16  frames completed (tlast accepted), wraps 0xFFFF->0

## Operation
- States: IDLE, SEND, GAP.
- IDLE: start=1 with frame_len!=0 -> latch len/seed, load beat 0 into output register, go SEND. start with frame_len=0 ignored (stay IDLE, no beat, no count).
- Beat k tdata = seed + k (mod 2^DATA_WIDTH); tlast=1 on k = len-1; tuser=0 unless abort/error rules apply.
- Handshake: beat transfers when tvalid & tready. Once tvalid is high, tdata/tlast/tuser held stable until transfer. tvalid never drops without a transfer (except reset).
- On transfer of non-last beat: load beat k+1 same edge (no bubble).
- On transfer of last beat: frame_count += 1; go GAP if GAP_CYCLES>0 else IDLE; tvalid low next cycle.
- GAP: counts GAP_CYCLES cycles, tvalid low, start ignored, then IDLE.
- abort in SEND: latched sticky. The next beat loaded (after current beat transfers) carries tlast=1, tuser=1 and ends the frame. If the currently presented beat already has tlast=1, abort is discarded and frame ends clean (tuser=0). Abort in IDLE/GAP ignored. Latch cleared on frame end.
- Aborted frame counts in frame_count.
- start during SEND/GAP ignored, not queued.

## Timing
- Reset values: tvalid=0, tdata=0, tlast=0, tuser=0, busy=0, frame_count=0, state IDLE, abort latch 0.
- start at edge N -> tvalid=1 with beat 0 from cycle N+1; busy=1 from N+1.
- Throughput: 1 beat/cycle with tready held high; frame of L beats occupies L cycles of tvalid.
- Frame-to-frame: last transfer at edge N -> GAP cycles N+1..N+GAP_CYCLES -> IDLE at N+GAP_CYCLES+1; earliest next beat one cycle later.
- abort asserted at edge N while beat k (non-last) presented and transferred at N -> beat k+1 at N+1 is the truncating tlast/tuser beat.
- frame_len=1: single beat with tlast=1.
- Reset mid-frame: tvalid drops next cycle with no tlast; downstream sees an unterminated frame (documented, intentional).

## Configuration
- AXIS_FRAME_GEN_ERR_INJ_EN defined: adds input port err_inject (1 bit), latched with start; frame sent at full length with tuser=1 on its last beat. Abort behaviour unchanged.
- Not defined: no err_inject port; tuser is 1 only on abort-truncated frames.

## Test plan
- start, len=4, seed=0xFE, tready=1 -> beats FE,FF,00,01 on 4 consecutive cycles, tlast on 01, tuser=0, frame_count=1, then 2 gap cycles tvalid=0.
- len=3, tready toggling 1/0 each cycle -> each beat held stable while tready=0; 3 transfers in order; no dropped/duplicated beats.
- len=10, seed=0, abort pulse when beat 2 transfers -> beat 3 data 0x03 with tlast=1, tuser=1; frame_count=1; no further beats.
- start with frame_len=0, and start during SEND -> both ignored; frame_count and output unchanged.
- rst asserted while beat 5 of a len=8 frame presented -> next cycle tvalid=0, busy=0, frame_count=0; fresh start then sends beat 0 normally.
- With AXIS_FRAME_GEN_ERR_INJ_EN, err_inject=1, len=2 -> 2 beats, tuser=1 on the tlast beat; next frame with err_inject=0 has tuser=0.
